// File: rtl/cbfp_pkg.sv
// Shared types, sizing constants and the shift saturation helper for the CBFP scheduler.
package cbfp_pkg;

    localparam int unsigned MAG_WIDTH = 6;
    localparam int unsigned LANES     = 4;
    localparam int unsigned BLK_LEN   = 16;
    localparam int unsigned MAX_SHIFT = 23;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BEATS     = BLK_LEN / LANES;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned MAG_BUS_W = LANES * MAG_WIDTH;

    typedef logic [MAG_WIDTH-1:0] mag_t;

    typedef struct packed {
        mag_t             shift;
        logic [CNT_W-1:0] seq;
    } shift_entry_t;

    // Clamp a block minimum to the largest shift the downstream shifter supports.
    function automatic mag_t sat_shift(input mag_t m);
        return (m > MAG_WIDTH'(MAX_SHIFT)) ? MAG_WIDTH'(MAX_SHIFT) : m;
    endfunction

endpackage

// File: rtl/cbfp_shift_sched_if.sv
// Beat input / shift output bundle between magnitude-index stage, scheduler and CBFP shifter.
interface cbfp_shift_sched_if;
    import cbfp_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [MAG_BUS_W-1:0] in_mag;
    logic                 in_last;
    logic                 blk_abort;
    logic                 out_valid;
    logic                 out_ready;
    mag_t                 out_shift;
    logic [CNT_W-1:0]     out_blk_cnt;
    logic                 err_align;
    logic                 busy;

    modport master (
        output in_valid, in_mag, in_last, blk_abort, out_ready,
        input  in_ready, out_valid, out_shift, out_blk_cnt, err_align, busy
    );

    modport slave (
        input  in_valid, in_mag, in_last, blk_abort, out_ready,
        output in_ready, out_valid, out_shift, out_blk_cnt, err_align, busy
    );

endinterface

// File: rtl/cbfp_lane_min.sv
// Combinational unsigned minimum across LANES packed magnitude indices.
module cbfp_lane_min #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 6
) (
    input  logic [LANES*W-1:0] i_mag,
    output logic [W-1:0]       o_min_c
);

    // Linear scan with strict compare so the lowest lane wins ties.
    always_comb begin
        o_min_c = i_mag[W-1:0];
        for (int k = 1; k < int'(LANES); k++) begin
            if (i_mag[k*W +: W] < o_min_c) begin
                o_min_c = i_mag[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/cbfp_shift_sched.sv
// CBFP shift scheduler: per-block running minimum, 2-deep shift queue, alignment check.
module cbfp_shift_sched
    import cbfp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    cbfp_shift_sched_if.slave  bus
);

    mag_t               w_beat_min;
    mag_t               w_blk_min;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_close;
    logic               w_pop;
    logic               w_err_nxt;
    logic               w_busy_nxt;
    shift_entry_t       w_push_entry;

    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [BEAT_W-1:0]  w_beat_cnt_nxt;
    mag_t               r_run_min;
    mag_t               w_run_min_nxt;
    logic [CNT_W-1:0]   r_blk_seq;
    logic [CNT_W-1:0]   w_blk_seq_nxt;

    shift_entry_t       r_head;
    shift_entry_t       r_tail;
    shift_entry_t       w_head_nxt;
    shift_entry_t       w_tail_nxt;
    logic [1:0]         r_q_cnt;
    logic [1:0]         w_q_cnt_nxt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_err_align;
    logic               r_busy;

    cbfp_lane_min #(
        .LANES (LANES),
        .W     (MAG_WIDTH)
    ) u_lane_min (
        .i_mag   (bus.in_mag),
        .o_min_c (w_beat_min)
    );

    assign w_accept     = bus.in_valid & r_in_ready & ~bus.blk_abort;
    assign w_last_beat  = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_close      = w_accept & (bus.in_last | w_last_beat);
    assign w_pop        = r_out_valid & bus.out_ready;
    assign w_blk_min    = (w_beat_min < r_run_min) ? w_beat_min : r_run_min;
    assign w_push_entry = '{shift: sat_shift(w_blk_min), seq: r_blk_seq};
    assign w_err_nxt    = w_close & (bus.in_last ^ w_last_beat);

    // Block accumulation: abort discards, close restarts, plain beats fold into the minimum.
    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        w_run_min_nxt  = r_run_min;
        w_blk_seq_nxt  = r_blk_seq;
        if (bus.blk_abort) begin
            w_beat_cnt_nxt = '0;
            w_run_min_nxt  = '1;
        end else if (w_close) begin
            w_beat_cnt_nxt = '0;
            w_run_min_nxt  = '1;
            w_blk_seq_nxt  = r_blk_seq + CNT_W'(1);
        end else if (w_accept) begin
            w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
            w_run_min_nxt  = w_blk_min;
        end
    end

    // Two-entry queue; head is the registered output payload and only moves on pop.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_q_cnt_nxt = r_q_cnt;
        case (r_q_cnt)
            2'd0: begin
                if (w_close) begin
                    w_head_nxt  = w_push_entry;
                    w_q_cnt_nxt = 2'd1;
                end
            end
            2'd1: begin
                if (w_close && w_pop) begin
                    w_head_nxt  = w_push_entry;
                end else if (w_close) begin
                    w_tail_nxt  = w_push_entry;
                    w_q_cnt_nxt = 2'd2;
                end else if (w_pop) begin
                    w_q_cnt_nxt = 2'd0;
                end
            end
            default: begin
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_q_cnt_nxt = 2'd1;
                end
            end
        endcase
    end

    assign w_busy_nxt = (w_beat_cnt_nxt != '0) | (w_q_cnt_nxt != 2'd0);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_run_min   <= '1;
            r_blk_seq   <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_q_cnt     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err_align <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_run_min   <= w_run_min_nxt;
            r_blk_seq   <= w_blk_seq_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_q_cnt     <= w_q_cnt_nxt;
            r_in_ready  <= (w_q_cnt_nxt != 2'd2);
            r_out_valid <= (w_q_cnt_nxt != 2'd0);
            r_err_align <= w_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_shift   = r_head.shift;
    assign bus.out_blk_cnt = r_head.seq;
    assign bus.err_align   = r_err_align;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_cbfp_shift_sched.sv
// Directed bench for the CBFP shift scheduler with hand-computed expectations.
module tb_cbfp_shift_sched;
    import cbfp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cbfp_shift_sched_if bus ();

    cbfp_shift_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [MAG_BUS_W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [MAG_BUS_W-1:0] v;
        v = '0;
        v[0*MAG_WIDTH +: MAG_WIDTH] = MAG_WIDTH'(a);
        v[1*MAG_WIDTH +: MAG_WIDTH] = MAG_WIDTH'(b);
        v[2*MAG_WIDTH +: MAG_WIDTH] = MAG_WIDTH'(c);
        v[3*MAG_WIDTH +: MAG_WIDTH] = MAG_WIDTH'(d);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic send_beat(input logic [MAG_BUS_W-1:0] mag, input logic last);
        int budget;
        budget       = 0;
        bus.in_valid = 1'b1;
        bus.in_mag   = mag;
        bus.in_last  = last;
        while (!bus.in_ready && budget < 200) begin
            tick();
            budget++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Four aligned beats whose overall minimum is m (lands in beat 2, lane 2).
    task automatic send_block4(input int m);
        send_beat(pack4(m+4, m+2, m+1, m+3), 1'b0);
        send_beat(pack4(m+1, m+5, m+2, m+2), 1'b0);
        send_beat(pack4(m+3, m+3, m,   m+7), 1'b0);
        send_beat(pack4(m+2, m+6, m+4, m+1), 1'b1);
    endtask

    // Wait for an output, compare it, and consume it; leaves out_ready high.
    task automatic pop_expect(input string tag, input int shift, input int seq);
        int budget;
        budget        = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && budget < 200) begin
            tick();
            budget++;
        end
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_shift"}, 32'(bus.out_shift), 32'(shift));
        check_eq({tag, "_seq"},   32'(bus.out_blk_cnt), 32'(seq));
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  32'(bus.in_ready),    32'd1);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
        check_eq({tag, "_out_shift"}, 32'(bus.out_shift),   32'd0);
        check_eq({tag, "_blk_cnt"},   32'(bus.out_blk_cnt), 32'd0);
        check_eq({tag, "_err"},       32'(bus.err_align),   32'd0);
        check_eq({tag, "_busy"},      32'(bus.busy),        32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mag    = '0;
        bus.in_last   = 1'b0;
        bus.blk_abort = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic block: mins 7,6,5,8 -> 5, seq 0
        send_beat(pack4(9, 7, 12, 8),   1'b0);
        send_beat(pack4(6, 11, 10, 13), 1'b0);
        send_beat(pack4(14, 5, 9, 9),   1'b0);
        check_eq("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_busy_partial",   32'(bus.busy),      32'd1);
        send_beat(pack4(8, 8, 8, 8),    1'b1);
        check_eq("t1_err", 32'(bus.err_align), 32'd0);
        pop_expect("t1", 5, 0);
        bus.out_ready = 1'b0;
        check_eq("t1_empty_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_idle_busy",   32'(bus.busy),      32'd0);

        // Back-pressure: two blocks fill the queue, third stalls
        apply_reset();
        send_block4(3);
        check_eq("t2_ready_one", 32'(bus.in_ready), 32'd1);
        send_block4(4);
        check_eq("t2_ready_full", 32'(bus.in_ready),    32'd0);
        check_eq("t2_head_shift", 32'(bus.out_shift),   32'd3);
        check_eq("t2_head_seq",   32'(bus.out_blk_cnt), 32'd0);
        fork
            send_block4(2);
            begin
                repeat (3) tick();
                check_eq("t2_stall_ready", 32'(bus.in_ready),    32'd0);
                check_eq("t2_hold_shift",  32'(bus.out_shift),   32'd3);
                check_eq("t2_hold_seq",    32'(bus.out_blk_cnt), 32'd0);
                pop_expect("t2a", 3, 0);
                pop_expect("t2b", 4, 1);
                pop_expect("t2c", 2, 2);
                bus.out_ready = 1'b0;
            end
        join
        check_eq("t2_drained", 32'(bus.out_valid), 32'd0);

        // Saturation: all 63 -> 23, and min 24 -> 23
        for (int b = 0; b < 4; b++) send_beat(pack4(63, 63, 63, 63), (b == 3));
        pop_expect("t3_sat63", 23, 3);
        bus.out_ready = 1'b0;
        send_block4(24);
        pop_expect("t3_sat24", 23, 4);
        bus.out_ready = 1'b0;

        // Early in_last on beat 1
        send_beat(pack4(20, 20, 20, 20), 1'b0);
        send_beat(pack4(15, 30, 16, 17), 1'b1);
        check_eq("t4_err_early", 32'(bus.err_align), 32'd1);
        pop_expect("t4_early", 15, 5);
        bus.out_ready = 1'b0;
        check_eq("t4_err_pulse", 32'(bus.err_align), 32'd0);
        for (int b = 0; b < 3; b++) send_beat(pack4(9 + b, 12, 10, 11), 1'b0);
        check_eq("t4_realign_valid", 32'(bus.out_valid), 32'd0);
        send_beat(pack4(13, 12, 14, 10), 1'b1);
        check_eq("t4_realign_err", 32'(bus.err_align), 32'd0);
        pop_expect("t4_realign", 9, 6);
        bus.out_ready = 1'b0;

        // Missing in_last on the fourth beat still closes, with an error pulse
        for (int b = 0; b < 4; b++) send_beat(pack4(12 + b, 14, 13, 20), 1'b0);
        check_eq("t4_err_missing", 32'(bus.err_align), 32'd1);
        pop_expect("t4_missing", 12, 7);
        bus.out_ready = 1'b0;
        check_eq("t4_err_clear", 32'(bus.err_align), 32'd0);

        // Abort after two beats, with a dropped beat in the abort cycle
        send_beat(pack4(1, 1, 1, 1), 1'b0);
        send_beat(pack4(1, 1, 1, 1), 1'b0);
        check_eq("t5_busy_partial", 32'(bus.busy), 32'd1);
        bus.blk_abort = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mag    = pack4(0, 0, 0, 0);
        bus.in_last   = 1'b1;
        tick();
        bus.blk_abort = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        check_eq("t5_abort_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t5_abort_busy",  32'(bus.busy),      32'd0);
        send_block4(6);
        pop_expect("t5_after_abort", 6, 8);
        bus.out_ready = 1'b0;
        check_eq("t5_single_out", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with a full queue
        send_block4(7);
        send_block4(8);
        check_eq("t6_full", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_block4(11);
        pop_expect("t6_post", 11, 0);
        bus.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
